// File: rtl/network_pkg.sv
// ---------------------------------------------------------------------------
// network_pkg
// Shared types and constants for the convolution datapath stages.
//   prod_t  : signed product word delivered by the 27-bit multiplier
//   act_t   : signed 16-bit activation word passed between layers
//   state_t : window accumulator control states (ACC, REQ, HOLD)
//   ACT_MAX / ACT_MIN : activation saturation limits
// ---------------------------------------------------------------------------
package network_pkg;

  typedef logic signed [26:0] prod_t;
  typedef logic signed [15:0] act_t;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam act_t ACT_MAX = 16'sh7FFF;
  localparam act_t ACT_MIN = 16'sh8000;

endpackage

// File: rtl/network_requant_sat.sv
// ---------------------------------------------------------------------------
// network_requant_sat
// Purely combinational requantiser: adds half an LSB, arithmetic-shifts right
// by SHIFT, saturates to an OUT_W signed range and optionally clamps negative
// values to zero.
//   i_acc : signed ACC_W-bit accumulator value
//   o_act : signed OUT_W-bit activation
// ---------------------------------------------------------------------------
module network_requant_sat #(
  parameter int ACC_W = 37,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_act
);

  // One guard bit keeps the rounding add from wrapping at the top of the
  // accumulator range.
  localparam logic signed [ACC_W:0] LP_HALF = (ACC_W+1)'(1) <<< (SHIFT-1);
  localparam logic signed [ACC_W:0] LP_MAX  =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] LP_MIN  =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0]   w_ext;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W:0]   w_shr;
  logic signed [OUT_W-1:0] w_sat;

  assign w_ext = {i_acc[ACC_W-1], i_acc};
  assign w_sum = w_ext + LP_HALF;
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_sat = w_shr[OUT_W-1:0];
    if (w_shr > LP_MAX) begin
      w_sat = LP_MAX[OUT_W-1:0];
    end else if (w_shr < LP_MIN) begin
      w_sat = LP_MIN[OUT_W-1:0];
    end
    o_act = w_sat;
    if ((RELU != 0) && w_sat[OUT_W-1]) begin
      o_act = '0;
    end
  end

endmodule

// File: rtl/network_acc_requant.sv
// ---------------------------------------------------------------------------
// network_acc_requant
// Sums one kernel window of signed products (delimited by in_last), adds a
// per-window bias, then rounds/shifts/saturates/ReLUs back to an activation
// presented on a valid/ready output.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : product beat handshake
//   in_data, in_last      : signed product, final beat of window
//   in_bias               : signed bias, sampled on the first beat of a window
//   out_valid/out_ready   : result handshake
//   out_data              : requantised activation
//   len_err               : sticky, a window exceeded MAX_LEN beats
// ---------------------------------------------------------------------------
module network_acc_requant
  import network_pkg::*;
#(
  parameter int PROD_W  = 27,
  parameter int ACC_W   = 37,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 10,
  parameter int MAX_LEN = 512,
  parameter int RELU    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_data,
  input  logic                     in_last,
  input  logic signed [OUT_W-1:0]  in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     len_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t                   r_state;
  state_t                   w_nextState;
  logic                     r_inReady;
  logic                     r_outValid;
  logic signed [OUT_W-1:0]  r_outData;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_beatCnt;
  logic                     r_lenErr;

  logic                     w_accept;
  logic                     w_atMax;
  logic signed [ACC_W-1:0]  w_biasExt;
  logic signed [ACC_W-1:0]  w_dataExt;
  logic signed [OUT_W-1:0]  w_act;

  assign w_accept  = in_valid & r_inReady;
  assign w_atMax   = (r_beatCnt == CNT_W'(MAX_LEN));
  assign w_biasExt = ACC_W'(in_bias) <<< SHIFT;
  assign w_dataExt = ACC_W'(in_data);

  network_requant_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_requant (
    .i_acc (r_acc),
    .o_act (w_act)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ACC:     if (w_accept && in_last) w_nextState = REQ;
      REQ:     w_nextState = HOLD;
      HOLD:    if (out_ready) w_nextState = ACC;
      default: w_nextState = ACC;
    endcase
  end

  // Handshake flags are decoded from the next state so they leave flops,
  // keeping out_ready off any combinational path to in_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ACC;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inReady  <= (w_nextState == ACC);
      r_outValid <= (w_nextState == HOLD);
    end
  end

  // Accumulate accepted beats; an over-long window keeps summing while the
  // counter parks at MAX_LEN and the sticky error is raised.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_beatCnt <= '0;
      r_lenErr  <= 1'b0;
      r_outData <= '0;
    end else begin
      if (w_accept) begin
        if (r_beatCnt == '0) begin
          r_acc <= w_biasExt + w_dataExt;
        end else begin
          r_acc <= r_acc + w_dataExt;
        end
        if (w_atMax) begin
          r_lenErr <= 1'b1;
        end else begin
          r_beatCnt <= r_beatCnt + CNT_W'(1);
        end
      end
      if (r_state == REQ) begin
        r_outData <= w_act;
        r_beatCnt <= '0;
      end
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign len_err   = r_lenErr;

endmodule

// File: tb/tb_network_acc_requant.sv
// ---------------------------------------------------------------------------
// tb_network_acc_requant
// Directed bench for the window accumulator / requantiser. Three instances
// share one stimulus stream: a plain one (RELU=0), a ReLU one (RELU=1) and a
// short-window one (MAX_LEN=4) for the length-overflow case.
// ---------------------------------------------------------------------------
module tb_network_acc_requant;
  import network_pkg::*;

  logic  clk;
  logic  reset_n;
  logic  inValid;
  prod_t inData;
  logic  inLast;
  act_t  inBias;
  logic  outReady;

  logic  inReady,  outValid,  lenErr;
  act_t  outData;
  logic  inReadyR, outValidR, lenErrR;
  act_t  outDataR;
  logic  inReadyL, outValidL, lenErrL;
  act_t  outDataL;

  int nChecks = 0;
  int nPassed = 0;

  network_acc_requant #(
    .PROD_W(27), .ACC_W(37), .OUT_W(16), .SHIFT(10), .MAX_LEN(512), .RELU(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_last(inLast), .in_bias(inBias),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .len_err(lenErr)
  );

  network_acc_requant #(
    .PROD_W(27), .ACC_W(37), .OUT_W(16), .SHIFT(10), .MAX_LEN(512), .RELU(1)
  ) dutRelu (
    .clk(clk), .reset_n(reset_n),
    .in_valid(inValid), .in_ready(inReadyR), .in_data(inData),
    .in_last(inLast), .in_bias(inBias),
    .out_valid(outValidR), .out_ready(outReady), .out_data(outDataR),
    .len_err(lenErrR)
  );

  network_acc_requant #(
    .PROD_W(27), .ACC_W(37), .OUT_W(16), .SHIFT(10), .MAX_LEN(4), .RELU(0)
  ) dutLen (
    .clk(clk), .reset_n(reset_n),
    .in_valid(inValid), .in_ready(inReadyL), .in_data(inData),
    .in_last(inLast), .in_bias(inBias),
    .out_valid(outValidL), .out_ready(outReady), .out_data(outDataL),
    .len_err(lenErrL)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one beat starting 1ns after an edge and returns 1ns after the
  // edge that accepted it.
  task automatic sendBeat(input prod_t d, input logic l, input act_t b);
    int guard;
    guard   = 0;
    inValid = 1'b1;
    inData  = d;
    inLast  = l;
    inBias  = b;
    while (!inReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!inReady) begin
      nChecks++;
      $display("[TB] FAIL beat_accept_timeout: in_ready=%0b required 1", inReady);
    end else begin
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  // Waits for a result, captures all three outputs and pops it.
  task automatic drainResult(output act_t dM, output act_t dR, output act_t dL);
    int guard;
    guard = 0;
    while (!outValid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!outValid) begin
      nChecks++;
      $display("[TB] FAIL result_timeout: out_valid=%0b required 1", outValid);
    end
    dM = outData;
    dR = outDataR;
    dL = outDataL;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inLast   = 1'b0;
    inBias   = '0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0b expected 1", inReady);
    else nPassed++;
    nChecks++;
    if (outValid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b expected 0", outValid);
    else nPassed++;
    nChecks++;
    if (outData !== 16'sd0) $display("[TB] FAIL reset_out_data: got %0d expected 0", outData);
    else nPassed++;
    nChecks++;
    if (lenErr !== 1'b0) $display("[TB] FAIL reset_len_err: got %0b expected 0", lenErr);
    else nPassed++;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sendBeat(27'sd1024, 1'b0, 16'sd0);
    sendBeat(27'sd2048, 1'b0, 16'sd0);
    sendBeat(27'sd512,  1'b1, 16'sd0);
    nChecks++;
    if (outValid !== 1'b0) $display("[TB] FAIL basic_req_valid: got %0b expected 0", outValid);
    else nPassed++;
    nChecks++;
    if (inReady !== 1'b0) $display("[TB] FAIL basic_req_ready: got %0b expected 0", inReady);
    else nPassed++;
    @(posedge clk); #1;
    nChecks++;
    if (outValid !== 1'b1) $display("[TB] FAIL basic_valid_t2: got %0b expected 1", outValid);
    else nPassed++;
    nChecks++;
    if (outData !== 16'sd4) $display("[TB] FAIL basic_data: got %0d expected 4", outData);
    else nPassed++;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    nChecks++;
    if (outValid !== 1'b0) $display("[TB] FAIL basic_pop_valid: got %0b expected 0", outValid);
    else nPassed++;
    nChecks++;
    if (inReady !== 1'b1) $display("[TB] FAIL basic_pop_ready: got %0b expected 1", inReady);
    else nPassed++;
  endtask

  task automatic test_negative();
    act_t dM, dR, dL;
    sendBeat(-27'sd1536, 1'b1, 16'sd0);
    drainResult(dM, dR, dL);
    nChecks++;
    if (dM !== -16'sd1) $display("[TB] FAIL neg_round: got %0d expected -1", dM);
    else nPassed++;
    nChecks++;
    if (dR !== 16'sd0) $display("[TB] FAIL neg_relu: got %0d expected 0", dR);
    else nPassed++;
  endtask

  task automatic test_saturation();
    act_t dM, dR, dL;
    sendBeat(27'sd1024, 1'b1, 16'sd32767);
    drainResult(dM, dR, dL);
    nChecks++;
    if (dM !== 16'sd32767) $display("[TB] FAIL sat_pos: got %0d expected 32767", dM);
    else nPassed++;
    nChecks++;
    if (dR !== 16'sd32767) $display("[TB] FAIL sat_pos_relu: got %0d expected 32767", dR);
    else nPassed++;
    sendBeat(-27'sd2048, 1'b1, -16'sd32768);
    drainResult(dM, dR, dL);
    nChecks++;
    if (dM !== -16'sd32768) $display("[TB] FAIL sat_neg: got %0d expected -32768", dM);
    else nPassed++;
    nChecks++;
    if (dR !== 16'sd0) $display("[TB] FAIL sat_neg_relu: got %0d expected 0", dR);
    else nPassed++;
  endtask

  task automatic test_backpressure();
    act_t dM, dR, dL;
    int guard;
    sendBeat(27'sd3072, 1'b1, 16'sd0);
    guard = 0;
    while (!outValid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    // Upstream parks its next beat while the result is held.
    inValid = 1'b1;
    inData  = 27'sd7168;
    inLast  = 1'b1;
    inBias  = 16'sd0;
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (outValid !== 1'b1 || outData !== 16'sd3 || inReady !== 1'b0)
        $display("[TB] FAIL bp_hold_%0d: valid=%0b data=%0d ready=%0b expected 1/3/0",
                 i, outValid, outData, inReady);
      else nPassed++;
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    nChecks++;
    if (inReady !== 1'b1 || outValid !== 1'b0)
      $display("[TB] FAIL bp_release: ready=%0b valid=%0b expected 1/0", inReady, outValid);
    else nPassed++;
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    nChecks++;
    if (inReady !== 1'b0) $display("[TB] FAIL bp_next_accept: in_ready=%0b expected 0", inReady);
    else nPassed++;
    drainResult(dM, dR, dL);
    nChecks++;
    if (dM !== 16'sd7) $display("[TB] FAIL bp_next_data: got %0d expected 7", dM);
    else nPassed++;
  endtask

  task automatic test_length();
    act_t dM, dR, dL;
    for (int i = 0; i < 4; i++) sendBeat(27'sd1024, 1'b0, 16'sd0);
    nChecks++;
    if (lenErrL !== 1'b0) $display("[TB] FAIL len_before: got %0b expected 0", lenErrL);
    else nPassed++;
    sendBeat(27'sd1024, 1'b1, 16'sd0);
    drainResult(dM, dR, dL);
    nChecks++;
    if (lenErrL !== 1'b1) $display("[TB] FAIL len_set: got %0b expected 1", lenErrL);
    else nPassed++;
    nChecks++;
    if (dL !== 16'sd5) $display("[TB] FAIL len_data: got %0d expected 5", dL);
    else nPassed++;
    nChecks++;
    if (lenErr !== 1'b0) $display("[TB] FAIL len_big_clear: got %0b expected 0", lenErr);
    else nPassed++;
    sendBeat(27'sd2048, 1'b1, 16'sd0);
    drainResult(dM, dR, dL);
    nChecks++;
    if (lenErrL !== 1'b1) $display("[TB] FAIL len_sticky: got %0b expected 1", lenErrL);
    else nPassed++;
    nChecks++;
    if (dL !== 16'sd2) $display("[TB] FAIL len_after_data: got %0d expected 2", dL);
    else nPassed++;
  endtask

  task automatic test_async_reset();
    act_t dM, dR, dL;
    sendBeat(27'sd1024, 1'b0, 16'sd5);
    sendBeat(27'sd1024, 1'b0, 16'sd5);
    #2 reset_n = 1'b0;
    #1;
    nChecks++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || outData !== 16'sd0)
      $display("[TB] FAIL areset_outputs: ready=%0b valid=%0b data=%0d expected 1/0/0",
               inReady, outValid, outData);
    else nPassed++;
    nChecks++;
    if (lenErrL !== 1'b0 || outDataL !== 16'sd0)
      $display("[TB] FAIL areset_len: len_err=%0b data=%0d expected 0/0", lenErrL, outDataL);
    else nPassed++;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    sendBeat(27'sd0, 1'b1, 16'sd1);
    drainResult(dM, dR, dL);
    nChecks++;
    if (dM !== 16'sd1) $display("[TB] FAIL areset_fresh: got %0d expected 1", dM);
    else nPassed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_length();
    test_async_reset();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
